// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_BYTES   : byte stride between consecutive instructions
//   fetch_entry_t : {pc, instr} queue entry at the core's default widths
//   FETCH_ASSERT  : clocked check used to catch queue overflow/underflow
package fetch_unit_pkg;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam int unsigned FETCH_ADDR_W  = 64;
    localparam int unsigned FETCH_INSTR_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

`ifndef FETCH_ASSERT
`define FETCH_ASSERT(clk, off, cond, msg) \
    assert property (@(posedge clk) disable iff (off) (cond)) else $error(msg);
`endif

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req/imem_addr/imem_ready      : request channel (fetch -> imem)
//   imem_rvalid/imem_rdata             : in-order response channel (imem -> fetch)
//   out_valid/out_ready/out_instr/
//   out_pc/out_pc_next                 : instruction stream (fetch -> decode)
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_next;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next,
        input  imem_ready, imem_rvalid, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_next,
        output imem_ready, imem_rvalid, imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
//   clk   : clock
//   clear : empties the FIFO; wins over push
//   push  : write din at tail
//   din   : entry to write
//   pop   : drop head entry (caller only pops when count != 0)
//   count : occupancy, 0..DEPTH
//   head  : entry at head (valid when count != 0)
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Push into a full FIFO is legal when the head leaves the same
            // cycle: the write lands in the slot being vacated.
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    `FETCH_ASSERT(clk, clear, !(push && !pop && (count_q == CNT_W'(DEPTH))), "fetch_fifo overflow")
    `FETCH_ASSERT(clk, clear, !(pop && (count_q == '0)), "fetch_fifo underflow")

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction-fetch front end.
//   clk            : clock
//   rst            : synchronous active-high reset
//   redirect_valid : taken branch / redirect this cycle
//   redirect_pc    : redirect target (bits [1:0] ignored)
//   bus (master)   : imem request/response channels and the decode stream
// Requests are issued in order while queue occupancy plus outstanding
// requests stays below DEPTH, so every live response has a free slot.
// A redirect flushes the queue and marks all in-flight responses for drop.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 64,
    parameter int unsigned      INSTR_W  = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_unit_if.master      bus
);
    localparam int unsigned       CNT_W   = $clog2(DEPTH+1);
    localparam int unsigned       ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  resp_pc_q;
    logic [CNT_W-1:0]   outst_q;
    logic [CNT_W-1:0]   drop_q;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit_used;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  out_pc;
    logic               issue;
    logic               accept;
    logic               push;
    logic               pop;
    logic               clear;
    logic               out_valid;
    logic               unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits cover both buffered entries and requests still in memory.
    assign credit_used = {1'b0, count} + {1'b0, outst_q};
    assign issue       = !rst && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
    assign accept      = issue && bus.imem_ready;
    assign push        = !rst && !redirect_valid && bus.imem_rvalid && (drop_q == '0);
    assign out_valid   = !rst && !redirect_valid && (count != '0);
    assign pop         = out_valid && bus.out_ready;
    assign clear       = rst || redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight is stale; a response arriving now
            // is discarded here and no longer counts as outstanding.
            pc_q      <= redirect_target;
            resp_pc_q <= redirect_target;
            outst_q   <= outst_q - CNT_W'(bus.imem_rvalid);
            drop_q    <= outst_q - CNT_W'(bus.imem_rvalid);
        end else begin
            if (accept) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (push) begin
                resp_pc_q <= resp_pc_q + PC_STEP;
            end
            if (bus.imem_rvalid && (drop_q != '0)) begin
                drop_q <= drop_q - CNT_W'(1);
            end
            outst_q <= outst_q + CNT_W'(accept) - CNT_W'(bus.imem_rvalid);
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (clear),
        .push  (push),
        .din   ({resp_pc_q, bus.imem_rdata}),
        .pop   (pop),
        .count (count),
        .head  (head)
    );

    assign out_pc          = head[ENTRY_W-1 -: ADDR_W];
    assign bus.imem_req    = issue;
    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = head[INSTR_W-1:0];
    assign bus.out_pc      = out_pc;
    assign bus.out_pc_next = out_pc + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable
// latency, scoreboard of expected {pc, instr} filled on live responses and
// drained on decode handshakes, plus directed scenarios and an 8-bit
// address instance for PC wrap.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    fetch_unit #(
        .ADDR_W   (64),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master)
    );

    logic       rst8;
    logic       redirect_valid8;
    logic [7:0] redirect_pc8;
    fetch_unit_if #(.ADDR_W(8), .INSTR_W(32)) bus8 ();

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (8'hF8)
    ) dut8 (
        .clk            (clk),
        .rst            (rst8),
        .redirect_valid (redirect_valid8),
        .redirect_pc    (redirect_pc8),
        .bus            (bus8.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC3A5_5A3C;
    endfunction

    typedef struct { logic [63:0] addr; int unsigned due; int unsigned epoch; } mreq_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    logic [63:0] pop_log[$];
    int unsigned cyc       = 0;
    int unsigned epoch     = 0;
    int unsigned mem_lat   = 1;
    int unsigned n_issued  = 0;
    logic [63:0] exp_issue = 64'h0;
    bit          rnd_ready = 1'b0;
    bit          req_seen;
    bit          oval_seen;
    bit          popped;
    logic [63:0] req_addr;
    logic [63:0] popped_pc;

    // One clock cycle on the 64-bit instance: drive at negedge, sample 1ns later.
    task automatic step(input bit r, input bit redir, input logic [63:0] rpc, input bit ordy);
        mreq_t resp;
        exp_t  e;
        bit    got_resp;
        got_resp = 1'b0;
        @(negedge clk);
        rst            = r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        bus.out_ready  = ordy;
        bus.imem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        if (!r && mq.size() != 0 && mq[0].due <= cyc) begin
            resp            = mq.pop_front();
            got_resp        = 1'b1;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr_of(resp.addr);
        end
        #1;
        req_seen  = bus.imem_req;
        req_addr  = bus.imem_addr;
        oval_seen = bus.out_valid;
        popped    = 1'b0;
        if (r) begin
            check("rst_imem_req", 64'(bus.imem_req), 64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            mq.delete();
            sb.delete();
            epoch++;
            exp_issue = 64'h0;
        end else begin
            if (redir) begin
                check("redir_out_valid", 64'(bus.out_valid), 64'd0);
                check("redir_imem_req", 64'(bus.imem_req), 64'd0);
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else if (ordy) begin
                    e = sb.pop_front();
                    check("out_pc", bus.out_pc, e.pc);
                    check("out_instr", 64'(bus.out_instr), 64'(e.instr));
                    check("out_pc_next", bus.out_pc_next, e.pc + 64'd4);
                    popped    = 1'b1;
                    popped_pc = bus.out_pc;
                    pop_log.push_back(bus.out_pc);
                end
            end
            if (bus.imem_req) begin
                check("imem_addr", bus.imem_addr, exp_issue);
                if (bus.imem_ready) begin
                    mq.push_back('{bus.imem_addr, cyc + mem_lat, epoch});
                    exp_issue += 64'd4;
                    n_issued++;
                end
            end
            if (redir) begin
                epoch++;
                sb.delete();
                exp_issue = {rpc[63:2], 2'b00};
            end
            if (got_resp && resp.epoch == epoch) begin
                sb.push_back('{resp.addr, instr_of(resp.addr)});
                check("queue_overflow", 64'(sb.size() > DEPTH), 64'd0);
            end
        end
        cyc++;
    endtask

    // 8-bit instance: fixed 1-cycle memory that forgets its request on reset.
    bit         p8_v = 1'b0;
    logic [7:0] p8_a = 8'h0;
    logic [7:0] log8[$];
    bit         req8;
    bit         oval8;
    logic [7:0] addr8;

    task automatic step8(input bit r, input bit ordy);
        @(negedge clk);
        rst8             = r;
        bus8.out_ready   = ordy;
        bus8.imem_ready  = 1'b1;
        bus8.imem_rvalid = p8_v && !r;
        bus8.imem_rdata  = instr_of({56'h0, p8_a});
        #1;
        req8  = bus8.imem_req;
        oval8 = bus8.out_valid;
        addr8 = bus8.imem_addr;
        if (r) begin
            p8_v = 1'b0;
        end else begin
            p8_v = bus8.imem_req;
            p8_a = bus8.imem_addr;
            if (bus8.out_valid && ordy) begin
                log8.push_back(bus8.out_pc);
                check("t6_instr", 64'(bus8.out_instr), 64'(instr_of({56'h0, bus8.out_pc})));
                check("t6_pc_next", 64'(bus8.out_pc_next), 64'(8'(bus8.out_pc + 8'd4)));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        bit          rd;
        logic [7:0]  exp8 [4];

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.out_ready = 1'b0;
        rst8 = 1'b1; redirect_valid8 = 1'b0; redirect_pc8 = '0;
        bus8.imem_ready = 1'b1; bus8.imem_rvalid = 1'b0; bus8.imem_rdata = '0; bus8.out_ready = 1'b0;

        // Reset, first fetch, 1-cycle memory streaming
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        check("t1_imem_req", 64'(req_seen), 64'd1);
        check("t1_imem_addr", req_addr, 64'h0);
        check("t1_out_valid", 64'(oval_seen), 64'd0);
        step(0, 0, 0, 1);
        check("t2_out_valid_c2", 64'(oval_seen), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            check("t2_stream_pc", popped ? popped_pc : 64'hDEAD, 64'(i * 4));
        end

        // Decode stalled: credits stop issue at DEPTH, then drain in order
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        base = n_issued;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        check("t3_issued", 64'(n_issued - base), 64'd4);
        check("t3_req_stalled", 64'(req_seen), 64'd0);
        pop_log.delete();
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        check("t3_pop_count", 64'(pop_log.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++)
            check("t3_order", (pop_log.size() > i) ? pop_log[i] : '1, 64'(i * 4));

        // 3-cycle memory, redirect with 3 requests in flight
        mem_lat = 3;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 1, 64'h100, 1);
        pop_log.delete();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        check("t4_first_pc", (pop_log.size() != 0) ? pop_log[0] : '1, 64'h100);
        foreach (pop_log[i]) check("t4_no_stale", 64'(pop_log[i] < 64'h100), 64'd0);

        // Redirect onto a full queue with decode ready; unaligned target
        mem_lat = 1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        check("t5_full_before", 64'(oval_seen), 64'd1);
        step(0, 1, 64'h103, 1);
        check("t5_oval_on_redirect", 64'(oval_seen), 64'd0);
        pop_log.delete();
        step(0, 0, 0, 1);
        check("t5_empty_next", 64'(oval_seen), 64'd0);
        check("t5_req_target", req_addr, 64'h100);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        check("t5_first_pc", (pop_log.size() != 0) ? pop_log[0] : '1, 64'h100);

        // Random latency, memory stalls, decode stalls and redirects
        rnd_ready = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int seg = 0; seg < 8; seg++) begin
            mem_lat = $urandom_range(1, 4);
            for (int i = 0; i < 40; i++) begin
                rd = ($urandom_range(0, 15) == 0);
                step(0, rd, {32'h0, $urandom()}, 1'($urandom_range(0, 1)));
            end
        end
        // Stall decode until memory is quiet: queue must end up exactly full
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0);
        check("drain_mem_idle", 64'(mq.size()), 64'd0);
        check("drain_queue_full", 64'(sb.size()), 64'(DEPTH));
        check("drain_req_stopped", 64'(req_seen), 64'd0);
        check("drain_out_valid", 64'(oval_seen), 64'd1);
        step(1, 0, 0, 0);

        // 8-bit addresses: wrap from 0xFC to 0x00, reset mid-stream
        exp8[0] = 8'hF8; exp8[1] = 8'hFC; exp8[2] = 8'h00; exp8[3] = 8'h04;
        step8(1, 1);
        step8(1, 1);
        for (int i = 0; i < 8; i++) step8(0, 1);
        for (int i = 0; i < 4; i++)
            check("t6_wrap_pc", (log8.size() > i) ? 64'(log8[i]) : '1, 64'(exp8[i]));
        step8(1, 1);
        check("t6_rst_req", 64'(req8), 64'd0);
        check("t6_rst_oval", 64'(oval8), 64'd0);
        step8(0, 1);
        check("t6_after_rst_addr", 64'(addr8), 64'hF8);
        check("t6_after_rst_req", 64'(req8), 64'd1);
        check("t6_after_rst_empty", 64'(oval8), 64'd0);
        step8(0, 1);
        check("t6_no_stale_out", 64'(oval8), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
